// File: rtl/picosoc_mem_pipe_if.sv
// Request/response handshake bundle for picosoc_mem_pipe.
// The master issues requests and consumes responses; the slave is the memory.
interface picosoc_mem_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 22
) ();
  localparam int unsigned NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [NB-1:0]     req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/picosoc_mem_pipe.sv
// Single-port byte-writable word memory with valid/ready handshake, post-reset clear
// and range checking. Optional per-lane parity under `PICOSOC_MEM_PARITY_EN.
module picosoc_mem_pipe #(
  parameter int unsigned WORDS          = 256,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 22,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  picosoc_mem_pipe_if.slave   bus,
  input  logic                inj_par,
  output logic                init_done
);
  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned AW = $clog2(WORDS);
  localparam logic [ADDR_W:0] WordsExt = (ADDR_W + 1)'(WORDS);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            clr_last;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] mem_q [WORDS];

  logic              req_ready;
  logic              accept;
  logic              in_range;
  logic [AW-1:0]     req_idx;
  logic [DATA_W-1:0] rd_word;
  logic              par_err;

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;

  assign clr_last = (clr_cnt_q == AW'(WORDS - 1));
  assign in_range = ({1'b0, bus.req_addr} < WordsExt);
  assign req_idx  = AW'(bus.req_addr);
  assign accept   = bus.req_valid && req_ready;
  assign rd_word  = in_range ? mem_q[req_idx] : '0;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StInit: begin
        if (CLEAR_ON_RESET) begin
          clr_cnt_d = clr_cnt_q + AW'(1);
          if (clr_last) state_d = StRun;
        end else begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // FSM outputs: handshake and the single memory write port
  always_comb begin
    init_done = 1'b0;
    req_ready = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = clr_cnt_q;
    wr_data   = '0;
    wr_be     = '1;
    unique case (state_q)
      StInit: wr_en = CLEAR_ON_RESET;
      StRun: begin
        init_done = 1'b1;
        req_ready = !rsp_valid_q || bus.rsp_ready;
        wr_en     = accept && in_range;
        wr_idx    = req_idx;
        wr_data   = bus.req_wdata;
        wr_be     = bus.req_wen;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en && wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

`ifdef PICOSOC_MEM_PARITY_EN
  logic [NB-1:0] par_q [WORDS];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_par;

  // Clear writes correct (zero) parity; run-time writes may be deliberately corrupted.
  always_comb begin
    wr_par = '0;
    rd_par = in_range ? par_q[req_idx] : '0;
    for (int i = 0; i < NB; i++) begin
      if (state_q == StRun) wr_par[i] = (^bus.req_wdata[8*i +: 8]) ^ inj_par;
    end
  end

  always_comb begin
    par_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (in_range && (rd_par[i] != ^rd_word[8*i +: 8])) par_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en && wr_be[i]) par_q[wr_idx][i] <= wr_par[i];
    end
  end
`else
  logic unused_inj_par;
  assign unused_inj_par = inj_par;
  assign par_err        = 1'b0;
`endif

  // Response holds stable under backpressure because req_ready blocks new accepts.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = rd_word;
      rsp_err_d   = !in_range || par_err;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/picosoc_mem_pipe.md
# picosoc_mem_pipe

Parametrised single-port word memory for the PicoSoC-style local RAM path. It generalises the fixed 32-bit byte-write RAM in four ways: configurable data width and depth, a valid/ready request/response handshake with backpressure, a post-reset clear sequencer, and range checking. It sits between the CPU/bus adapter and on-chip RAM, and is also used as a scratchpad for DMA-style masters.

## Interface
- `WORDS`, 256: number of memory words; any value ≥ 2.
- `DATA_W`, 32: word width in bits; must be a multiple of 8. `NB = DATA_W/8` is the number of byte lanes.
- `ADDR_W`, 22: word-address width; must satisfy 2^ADDR_W ≥ WORDS.
- `CLEAR_ON_RESET`, 1: when 1, zero every word after reset.
- `clk`  in  1  clock; all logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  NB... no: 1  request accepted when `req_valid && req_ready`.
- `req_wen`  in  NB  byte write enables; all zero means read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  DATA_W  word content before the request's write (read-first).
- `rsp_err`  out  1  out-of-range address, or parity error when parity is built.
- `init_done`  out  1  clear sequence finished.
- `inj_par`  in  1  parity-error injection. Ignored unless `PICOSOC_MEM_PARITY_EN` is defined.

## Operation
- There are two states, INIT and RUN, and reset enters INIT.
- **INIT with `CLEAR_ON_RESET=1`:**
  - Counter `clr_cnt` starts at 0 and writes 0 to `mem[clr_cnt]` on each edge.
  - On the edge that writes `WORDS-1`, the block sets `init_done` and enters RUN.
- **INIT with `CLEAR_ON_RESET=0`:** the first edge after reset release sets `init_done` and enters RUN. Memory contents are then undefined.
- **RUN:** `req_ready = init_done && (!rsp_valid || rsp_ready)`. This is combinational from `rsp_ready`.
- On acceptance, the block registers `rsp_rdata <= mem[req_addr]` and, for each lane i with `req_wen[i]`, writes byte lane i of `req_wdata` into `mem[req_addr]`.
- Every accepted request, read or write, produces exactly one response.
- **Out of range (`req_addr ≥ WORDS`):**
  - No write occurs.
  - The response has `rsp_rdata = 0` and `rsp_err = 1`.
- While `rsp_valid && !rsp_ready`, `rsp_rdata` and `rsp_err` hold stable. No new request is accepted, so there is no lost data.
- Responses are returned strictly in order; at most one is outstanding.
- **Reset mid-operation:**
  - All outputs return to their reset values and any pending response is dropped.
  - INIT restarts at word 0. A partially completed clear restarts from 0.

## Timing
- **Reset values:**
  - `req_ready` = 0 (combinational, because `init_done` = 0).
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `init_done` = 0.
  - `clr_cnt` = 0.
- **Clear latency:** `init_done` goes high after exactly WORDS rising edges following reset release.
- **Response latency:** 1 cycle. A request accepted on edge N gives `rsp_valid` = 1 after edge N.
- **Throughput:** one request per cycle while `rsp_ready` = 1. Response accept and new request accept may occur on the same edge.
- **Back-to-back access to the same address:** the second request sees the first request's write, because it is read-first per request with writes committed at the edge.
- **Response only, no new request:** when `rsp_valid && rsp_ready && !(req_valid && req_ready)`, `rsp_valid` clears on that edge.

## Configuration
- Macro: `PICOSOC_MEM_PARITY_EN`.
- **Defined:**
  - Each byte lane stores an extra even-parity bit.
  - Parity is written as `^byte`, inverted when `inj_par` = 1 at acceptance. INIT writes correct parity.
  - On a read, any lane whose stored parity mismatches its data sets `rsp_err` = 1. Data is returned unmodified.
- **Undefined:**
  - No parity storage; memory is DATA_W bits wide.
  - `inj_par` is unused.
  - `rsp_err` reflects only out-of-range access.

## Test plan
- **Clear:** WORDS=16; release reset; count edges.
  - `init_done` rises after the 16th edge and `req_ready` is 0 before it.
  - Reads of addresses 0..15 return 0x00000000 with `rsp_err` = 0.
- **Byte lanes / read-first:**
  - Write 0xAABBCCDD, `wen`=4'b1111 to address 3; response `rdata` = 0x00000000.
  - Write 0x00001100, `wen`=4'b0010 to address 3; response `rdata` = 0xAABBCCDD.
  - Read address 3 returns 0xAABB11DD.
- **Backpressure:**
  - Hold `rsp_ready` = 0 for 5 cycles after one read of address 3.
  - `rsp_valid` stays 1 with `rdata` stable at 0xAABB11DD and `req_ready` = 0.
  - After `rsp_ready` rises, a queued read of address 0 completes next cycle.
- **Range:** with WORDS=16, write 0xFFFFFFFF to address 16, then read address 0.
  - The write response has `rsp_err` = 1 and `rdata` = 0.
  - The read of address 0 returns 0 (no aliasing).
- **Reset mid-init:** assert `resetn` = 0 at edge 7 of the clear, then release.
  - `init_done` = 0 immediately.
  - `init_done` rises a full 16 edges after the second release.
- **Parity (`PICOSOC_MEM_PARITY_EN` defined):**
  - Write 0x12345678 to address 2 with `inj_par` = 1, then read address 2.
  - The read returns `rdata` = 0x12345678 with `rsp_err` = 1.
  - A clean rewrite followed by a read gives `rsp_err` = 0.
